// File: rtl/scroll_message_display.sv
// Scrolling-message engine: circular message store with a NUM_DIGITS-wide window
// that advances on each divider expiry or manual step; outputs per-digit character codes.
module scroll_message_display #(
   parameter int                CLK_DIV    = 50000000,
   parameter int                NUM_DIGITS = 6,
   parameter int                MSG_LEN    = 8,
   parameter int                CHAR_W     = 2,
   parameter logic [CHAR_W-1:0] BLANK_CODE = 2'b11,
   localparam int               PTR_W      = (MSG_LEN > 1) ? $clog2(MSG_LEN) : 1
) (
   input  logic                           clock,
   input  logic                           reset,
   input  logic                           enable,
   input  logic                           dir,
   input  logic                           load,
   input  logic                           step,
   input  logic [MSG_LEN*CHAR_W-1:0]      msg_in,
   output logic [NUM_DIGITS*CHAR_W-1:0]   digits,
   output logic                           tick,
   output logic [PTR_W-1:0]               pos,
   output logic                           wrap
);

   localparam int DIV_W    = $clog2(CLK_DIV);
   localparam int SUM_W    = $clog2(MSG_LEN + NUM_DIGITS) + 1;
   localparam int REDUCE_N = (NUM_DIGITS - 1) / MSG_LEN + 1;

   logic [DIV_W-1:0]             divCount_q, divCount_d;
   logic [PTR_W-1:0]             pos_q, pos_d;
   logic [MSG_LEN*CHAR_W-1:0]    msg_q, msg_d;
   logic                         tick_q, tick_d;
   logic                         wrap_q, wrap_d;
   logic [NUM_DIGITS*CHAR_W-1:0] digits_q;
   wire  [NUM_DIGITS*CHAR_W-1:0] digits_d;
   logic                         tickCond;
   logic                         advance;

   always_ff @(posedge clock) begin
      if (reset) begin
         divCount_q <= '0;
         pos_q      <= '0;
         msg_q      <= {MSG_LEN{BLANK_CODE}};
         tick_q     <= 1'b0;
         wrap_q     <= 1'b0;
         digits_q   <= {NUM_DIGITS{BLANK_CODE}};
      end else begin
         divCount_q <= divCount_d;
         pos_q      <= pos_d;
         msg_q      <= msg_d;
         tick_q     <= tick_d;
         wrap_q     <= wrap_d;
         digits_q   <= digits_d;
      end
   end

   // Load wins over any advance; a coincident tick condition and step still move the pointer once.
   always_comb begin
      tickCond   = enable && (divCount_q == DIV_W'(CLK_DIV - 1));
      advance    = tickCond || step;
      divCount_d = divCount_q;
      pos_d      = pos_q;
      msg_d      = msg_q;
      tick_d     = 1'b0;
      wrap_d     = 1'b0;
      if (load) begin
         msg_d      = msg_in;
         pos_d      = '0;
         divCount_d = '0;
      end else begin
         tick_d = tickCond;
         if (enable) begin
            divCount_d = tickCond ? '0 : divCount_q + DIV_W'(1);
         end
         if (advance) begin
            if (!dir) begin
               if (pos_q == PTR_W'(MSG_LEN - 1)) begin
                  pos_d  = '0;
                  wrap_d = 1'b1;
               end else begin
                  pos_d = pos_q + PTR_W'(1);
               end
            end else begin
               if (pos_q == '0) begin
                  pos_d  = PTR_W'(MSG_LEN - 1);
                  wrap_d = 1'b1;
               end else begin
                  pos_d = pos_q - PTR_W'(1);
               end
            end
         end
      end
   end

   logic [CHAR_W-1:0] slot [MSG_LEN];

   for (genvar s = 0; s < MSG_LEN; s++) begin : gSlot
      assign slot[s] = msg_q[s*CHAR_W +: CHAR_W];
   end

   // Digit k shows slot (pos + NUM_DIGITS-1-k) mod MSG_LEN, reduced by repeated subtraction.
   for (genvar k = 0; k < NUM_DIGITS; k++) begin : gDigit
      logic [SUM_W-1:0]  idx;
      logic [CHAR_W-1:0] code;

      always_comb begin
         idx  = SUM_W'(pos_q) + SUM_W'(NUM_DIGITS - 1 - k);
         code = BLANK_CODE;
         for (int r = 0; r < REDUCE_N; r++) begin
            if (idx >= SUM_W'(MSG_LEN)) begin
               idx = idx - SUM_W'(MSG_LEN);
            end
         end
         for (int t = 0; t < MSG_LEN; t++) begin
            if (idx == SUM_W'(t)) begin
               code = slot[t];
            end
         end
      end

      assign digits_d[k*CHAR_W +: CHAR_W] = code;
   end

   assign digits = digits_q;
   assign tick   = tick_q;
   assign pos    = pos_q;
   assign wrap   = wrap_q;

endmodule

// File: doc/scroll_message_display.md
Name: scroll_message_display

Overview:
Parametrised scrolling-message engine for the seven-segment bank. It holds a loadable circular message of MSG_LEN character codes and shows a NUM_DIGITS-wide window onto it. The window advances once per CLK_DIV clock cycles, or on a manual step. Per-digit character codes feed the existing per-digit 7-seg character decoders; this block does no segment decoding.

Parameters:
CLK_DIV, 50000000, scroll period in clock cycles (>=2); 1 s at 50 MHz
NUM_DIGITS, 6, number of display digits driven (>=1)
MSG_LEN, 8, circular message length in characters (>=1)
CHAR_W, 2, character code width (2-bit set: 00=d, 01=E, 10=1, 11=blank)
BLANK_CODE, 2'b11, code loaded into every message slot at reset
PTR_W (localparam), clog2(MSG_LEN) with minimum 1, pointer width

Ports:
clock  in  1  system clock (CLOCK_50 at top level)
reset  in  1  synchronous, active-high reset
enable  in  1  1 = auto-scroll runs; 0 = divider and pointer frozen
dir  in  1  0 = scroll left (pointer increments); 1 = scroll right (pointer decrements)
load  in  1  one-cycle pulse; captures msg_in
step  in  1  one-cycle pulse; advances the window once, regardless of enable
msg_in  in  MSG_LEN*CHAR_W  message; slot i = bits [i*CHAR_W +: CHAR_W]
digits  out  NUM_DIGITS*CHAR_W  digit k code = bits [k*CHAR_W +: CHAR_W]; digit 0 = HEX0 (rightmost)
tick  out  1  one-cycle pulse when the divider expires
pos  out  PTR_W  current window pointer
wrap  out  1  one-cycle pulse when the pointer wraps

Behaviour:
- Single clock domain. All state updates on the posedge of clock.
- Reset (highest priority): all message slots = BLANK_CODE; divider = 0; pos = 0; tick = 0; wrap = 0; digits = all BLANK_CODE.
- Divider:
  - Counts 0..CLK_DIV-1 while enable=1.
  - tick = 1 for exactly one cycle, in the cycle after the divider holds CLK_DIV-1; the divider then returns to 0.
  - Tick period is exactly CLK_DIV cycles.
  - With enable=0, the divider holds its value and tick = 0.
- Advance event = tick-cycle condition (divider == CLK_DIV-1 and enable) OR step.
  - Coincident tick condition and step produce exactly one advance.
- On an advance event:
  - dir=0: pos <= pos+1, or 0 if pos == MSG_LEN-1.
  - dir=1: pos <= pos-1, or MSG_LEN-1 if pos == 0.
  - wrap pulses in the same cycle that pos takes its wrapped value.
  - With MSG_LEN=1, pos stays 0 and wrap pulses on every advance.
- load (priority over any advance in the same cycle):
  - message <= msg_in; pos <= 0; divider <= 0; no tick or wrap that cycle.
- Window mapping:
  - Digit k shows slot (pos + NUM_DIGITS-1-k) mod MSG_LEN.
  - The leftmost digit shows slot pos.
  - If MSG_LEN < NUM_DIGITS, the message repeats across the window.
- digits is registered. It reflects the pos and message values present after a clock edge, one cycle after those registers update (latency 1 from pos/message change to digits).
- Arithmetic:
  - Modulo index is computed without a divider. Since pos < MSG_LEN, the index sum is reduced by conditional subtraction, applied repeatedly per NUM_DIGITS/MSG_LEN bound, or by a generate-time constant table.
  - No width truncation of the index sum.
- enable toggling mid-period resumes from the held divider value. The period is not restarted.
- dir may change at any cycle; it takes effect on the next advance.
- reset asserted mid-scroll overrides load and step in the same cycle.

Test Plan:
- Reset then load: CLK_DIV=4, NUM_DIGITS=6, MSG_LEN=8, msg slots 0..7 = d,E,1,_,_,_,_,_.
  - Assert reset 2 cycles -> digits all 11, pos=0, tick=0.
  - Pulse load -> one cycle later pos=0; next cycle digits HEX5..HEX0 = d E 1 _ _ _.
- Auto-scroll, dir=0, enable=1, after load:
  - tick every 4th cycle.
  - After first advance, pos=1 and digits = E 1 _ _ _ _.
  - After 7 advances, pos=7 and digits = _ d E 1 _ _.
  - 8th advance -> pos=0 with wrap=1 for one cycle.
- Right scroll: dir=1 from pos=0 -> pos=7, wrap=1, digits = _ d E 1 _ _; next advance -> pos=6.
- Pause/step:
  - enable=0 for 20 cycles -> pos and divider unchanged, tick=0.
  - Pulse step -> pos advances by exactly 1.
  - step coincident with the tick condition (enable=1) -> single advance.
- Priority:
  - load and tick condition in the same cycle -> pos=0, divider=0, no wrap.
  - reset with load in the same cycle -> message all blank.
- Small message: MSG_LEN=3 (d,E,1), NUM_DIGITS=6 -> digits = d E 1 d E 1; one advance -> E 1 d E 1 d.
